// File: rtl/pc_gen_if.sv
// ============================================================================
//  pc_gen_if : fetch-side signal bundle shared by pc_gen and its environment.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_gen_if;
    logic        IFID_Flush;
    logic [31:0] EXE_BranchTarget;
    logic        Exc_Flush;
    logic [31:0] Exc_Vector;
    logic        PC_Stall;
    logic        inst_addr_ok;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] IF_PC;
    logic        IF_Valid;
    logic        pc_adel;

    modport master (
        input  IFID_Flush, EXE_BranchTarget, Exc_Flush, Exc_Vector,
        input  PC_Stall, inst_addr_ok,
        output inst_req, inst_addr, IF_PC, IF_Valid, pc_adel
    );

    modport slave (
        output IFID_Flush, EXE_BranchTarget, Exc_Flush, Exc_Vector,
        output PC_Stall, inst_addr_ok,
        input  inst_req, inst_addr, IF_PC, IF_Valid, pc_adel
    );
endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
//  pc_gen : fetch PC generator with redirect queueing and memory handshake.
//  Optional: PC_ALIGN_CHECK_EN enables the misaligned-fetch flag pc_adel.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen (
    input  wire logic clk,
    input  wire logic resetn,
    pc_gen_if.master  bus
);
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

    state_t      r_state;
    logic [31:0] r_inst_addr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_pend_valid;
    logic        r_pend_exc;
    logic [31:0] r_pend_tgt;

    logic        w_inst_req;
    logic        w_handshake;
    logic        w_redir_valid;
    logic        w_redir_exc;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_seq_addr;

    // Merge live and pending redirects: exceptions always beat branches,
    // and a live request of equal rank supersedes the pending one.
    always_comb begin
        w_redir_valid = 1'b0;
        w_redir_exc   = 1'b0;
        w_redir_tgt   = r_pend_tgt;
        if (bus.Exc_Flush) begin
            w_redir_valid = 1'b1;
            w_redir_exc   = 1'b1;
            w_redir_tgt   = bus.Exc_Vector;
        end else if (r_pend_valid && r_pend_exc) begin
            w_redir_valid = 1'b1;
            w_redir_exc   = 1'b1;
            w_redir_tgt   = r_pend_tgt;
        end else if (bus.IFID_Flush) begin
            w_redir_valid = 1'b1;
            w_redir_tgt   = bus.EXE_BranchTarget;
        end else begin
            w_redir_valid = r_pend_valid;
            w_redir_tgt   = r_pend_tgt;
        end
    end

    assign w_inst_req  = (r_state == S_WAIT) || ((r_state == S_FETCH) && !bus.PC_Stall);
    assign w_handshake = w_inst_req && bus.inst_addr_ok;
    assign w_seq_addr  = r_inst_addr + 32'd4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_BOOT;
            r_inst_addr  <= c_RESET_PC;
            r_if_pc      <= c_RESET_PC;
            r_if_valid   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_exc   <= 1'b0;
            r_pend_tgt   <= 32'd0;
        end else begin
            r_if_valid <= 1'b0;
            if (w_handshake) begin
                // Any redirect still outstanding at acceptance means this
                // request was fetched down the wrong path, so it is squashed.
                r_if_pc      <= r_inst_addr;
                r_if_valid   <= !w_redir_valid;
                r_inst_addr  <= w_redir_valid ? w_redir_tgt : w_seq_addr;
                r_pend_valid <= 1'b0;
                r_state      <= S_FETCH;
            end else begin
                case (r_state)
                    S_BOOT: r_state <= S_FETCH;
                    S_FETCH: begin
                        if (w_redir_valid) begin
                            r_inst_addr  <= w_redir_tgt;
                            r_pend_valid <= 1'b0;
                        end
                        if (bus.PC_Stall)
                            r_state <= S_HOLD;
                        else if (!w_redir_valid)
                            r_state <= S_WAIT;
                    end
                    S_WAIT, S_HOLD: begin
                        if ((r_state == S_HOLD) && !bus.PC_Stall) begin
                            if (w_redir_valid)
                                r_inst_addr <= w_redir_tgt;
                            r_pend_valid <= 1'b0;
                            r_state      <= S_FETCH;
                        end else if (w_redir_valid) begin
                            r_pend_valid <= 1'b1;
                            r_pend_exc   <= w_redir_exc;
                            r_pend_tgt   <= w_redir_tgt;
                        end
                    end
                    default: r_state <= S_BOOT;
                endcase
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_pc_adel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_pc_adel <= 1'b0;
        else
            r_pc_adel <= w_handshake && !w_redir_valid && (r_inst_addr[1:0] != 2'b00);
    end

    assign bus.pc_adel = r_pc_adel;
`else
    assign bus.pc_adel = 1'b0;
`endif

    assign bus.inst_req  = w_inst_req;
    assign bus.inst_addr = r_inst_addr;
    assign bus.IF_PC     = r_if_pc;
    assign bus.IF_Valid  = r_if_valid;

endmodule

`default_nettype wire
